// File: rtl/debounce_sync_if.sv
// Pin-side bundle for the debouncer: raw input in, conditioned level and
// qualification flag out.
interface debounce_sync_if;
  logic in;
  logic db;
  logic busy;

  modport master (output in, input db, input busy);
  modport slave  (input in, output db, output busy);
endinterface

// File: rtl/debounce_sync.sv
// Two-flop synchroniser plus counter-qualified debounce FSM; db only moves
// after the synchronised input has held the new level for CYCLES clocks.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_ZERO  | stable low, db=0
//   ST_WAIT1 | candidate rise being qualified, db still 0
//   ST_ONE   | stable high, db=1
//   ST_WAIT0 | candidate fall being qualified, db still 1
module debounce_sync #(
  parameter  int CYCLES = 500000,
  localparam int W      = $clog2(CYCLES + 1)
) (
  input  logic           clk,
  input  logic           reset,
  debounce_sync_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ZERO  = 2'd0,
    ST_WAIT1 = 2'd1,
    ST_ONE   = 2'd2,
    ST_WAIT0 = 2'd3
  } state_t;

  localparam logic [W-1:0] RELOAD = W'(CYCLES - 1);

  logic   s0_q, s0_d;
  logic   s1_q, s1_d;
  state_t state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic   db_q, db_d;
  logic   busy_q, busy_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      state_q <= ST_ZERO;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    s0_d    = bus.in;
    s1_d    = s0_q;
    state_d = state_q;
    cnt_d   = cnt_q;

    // Zero is tested before decrementing, so the counter never wraps.
    case (state_q)
      ST_ZERO: begin
        if (s1_q) begin
          state_d = ST_WAIT1;
          cnt_d   = RELOAD;
        end
      end
      ST_WAIT1: begin
        if (!s1_q)             state_d = ST_ZERO;
        else if (cnt_q == '0)  state_d = ST_ONE;
        else                   cnt_d   = cnt_q - 1'b1;
      end
      ST_ONE: begin
        if (!s1_q) begin
          state_d = ST_WAIT0;
          cnt_d   = RELOAD;
        end
      end
      ST_WAIT0: begin
        if (s1_q)              state_d = ST_ONE;
        else if (cnt_q == '0)  state_d = ST_ZERO;
        else                   cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_ZERO;
    endcase

    db_d   = (state_d == ST_ONE)   || (state_d == ST_WAIT0);
    busy_d = (state_d == ST_WAIT1) || (state_d == ST_WAIT0);
  end

  assign bus.db   = db_q;
  assign bus.busy = busy_q;

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Conditions a raw, asynchronous, bouncy input (push-button or switch pin) into a clean, clock-synchronous level.
- Sits directly upstream of the edge_trigger stage; the db output drives edge_trigger's level input.
- Two-flop synchroniser followed by a counter-qualified four-state debounce FSM.
- A level change reaches db only after the synchronised input has held steady for CYCLES consecutive clocks.

Parameters:
- CYCLES, 500000, required stable-hold clocks (10 ms at 50 MHz). Legal range is 1 or greater.
- W, $clog2(CYCLES+1), debounce counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted); deassertion is synchronous to clk at the system level.
- in  input  1  raw asynchronous input; may glitch and bounce.
- db  output  1  debounced, synchronised level; registered.
- busy  output  1  1 while a candidate level change is being qualified (FSM in a WAIT state); registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - sync flops s0 and s1 = 0.
  - FSM = ZERO; counter = 0.
  - db = 0; busy = 0.
  - Reset asserted mid-qualification aborts immediately, with no db change beyond forcing it to 0.
- Synchroniser: each edge, s0 <= in and s1 <= s0. The FSM uses s1 only; in never feeds logic directly.
- FSM states: ZERO, WAIT1, ONE, WAIT0 (2-bit encoding free). Transitions per rising edge:
  - ZERO: s1=1 -> WAIT1, counter <= CYCLES-1. Otherwise stay.
  - WAIT1:
    - s1=0 -> ZERO (bounce rejected; counter don't-care).
    - else counter=0 -> ONE.
    - else counter <= counter-1.
  - ONE: s1=0 -> WAIT0, counter <= CYCLES-1. Otherwise stay.
  - WAIT0:
    - s1=1 -> ONE.
    - else counter=0 -> ZERO.
    - else counter <= counter-1.
- Outputs are registered from the next state:
  - db = 1 in ONE and WAIT0; 0 in ZERO and WAIT1. db therefore holds its old value throughout qualification.
  - busy = 1 in WAIT1 and WAIT0.
- Latency: if in changes before edge E0 and stays put, db changes after edge E0+CYCLES+2. With CYCLES=1 this is E0+3.
- Rejection: any s1 reversal during a WAIT state returns to the prior stable state.
  - db is unchanged and busy drops the next edge.
  - A fresh reversal restarts qualification from CYCLES-1; partial counts never accumulate.
- Counter never underflows: it is checked for 0 before decrementing. No wrap-around.
- Reset released with in held at 1: ZERO -> WAIT1 occurs normally. db rises after CYCLES+2 edges counted from the first post-release edge.
- db toggles at most once per CYCLES+1 clocks, so the downstream edge_trigger sees at most one tick per qualified transition.

Test Plan (CYCLES=4, T=20 ns, the bench applies in changes on negedge clk):
- Reset asserted, in=1 -> db=0, busy=0 throughout. Release reset, hold in=1 -> busy=1 after 3rd post-release edge; db=1 after 7th edge (E0+6); busy=0 on the same edge.
- Clean rise: from db=0, set in=1 before edge E0 and hold 10 cycles -> db=0 through edge E0+5, db=1 after edge E0+6.
- Glitch: from db=0, in=1 for 3 cycles then 0 -> busy pulses 1 for 3 cycles, db remains 0 for 20 cycles.
- Bounce then settle: from db=1, in toggles 0,1,0,1,0 each cycle then holds 0 from edge E0 -> db stays 1 until exactly edge E0+6, then db=0.
- Reset mid-operation: in rises, assert reset at edge E0+4 (in WAIT1) -> db=0 and busy=0 immediately, asynchronously. Release with in=1 -> full 6-edge qualification restarts.
- Chained with edge_trigger (en=1): two qualified rises 20 cycles apart plus interleaved 2-cycle glitches -> exactly two tick pulses.
